// File: rtl/multiword_add_pkg.sv
// Shared types and constants for the nibble-serial multiword adder.
package multiword_add_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mwa_state_t;

endpackage

// File: rtl/nibble_adder_ci.sv
// 4-bit ripple-carry adder slice with carry-in; purely combinational.
module nibble_adder_ci (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);

    // Ripple the carry bit by bit from the LSB.
    always_comb begin
        logic c;
        c   = ci;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Nibble-serial (4*NWORDS)-bit adder with valid/ready operand and result handshakes.
// Optional subtract support (in_sub port) when MULTIWORD_ADD_SUB_EN is defined.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int unsigned NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*NWORDS-1:0] in_a,
    input  logic [SLICE_W*NWORDS-1:0] in_b,
`ifdef MULTIWORD_ADD_SUB_EN
    input  logic                      in_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*NWORDS-1:0] out_sum,
    output logic                      out_carry,
    output logic                      busy
);

    localparam int unsigned W     = SLICE_W * NWORDS;
    localparam int unsigned CNT_W = $clog2(NWORDS + 1);

    mwa_state_t           state_q;
    mwa_state_t           state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [W-1:0]         res_q;
    logic                 carry_q;

    logic                 sub_c;
    logic                 accept_c;
    logic                 last_c;
    logic [SLICE_W-1:0]   slice_sum_c;
    logic                 slice_co_c;
    logic [W-1:0]         res_next_c;

`ifdef MULTIWORD_ADD_SUB_EN
    assign sub_c = in_sub;
`else
    assign sub_c = 1'b0;
`endif

    // Handshake and sequencing decodes.
    assign in_ready   = (state_q == IDLE) && !rst;
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign accept_c   = in_valid && in_ready;
    assign last_c     = (state_q == RUN) && (cnt_q == CNT_W'(NWORDS - 1));
    // New nibble enters at the MSB end; works for NWORDS=1 as well.
    assign res_next_c = W'({slice_sum_c, res_q} >> SLICE_W);

    // Single shared adder slice working on the low nibble of each operand register.
    nibble_adder_ci u_slice (
        .a   (a_q[SLICE_W-1:0]),
        .b   (b_q[SLICE_W-1:0]),
        .ci  (carry_q),
        .sum (slice_sum_c),
        .co  (slice_co_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)  state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand capture, nibble shifting, carry chaining and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        a_q     <= in_a;
                        b_q     <= sub_c ? ~in_b : in_b;
                        carry_q <= sub_c;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE_W;
                    b_q     <= b_q >> SLICE_W;
                    res_q   <= res_next_c;
                    carry_q <= slice_co_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        out_sum   <= res_next_c;
                        out_carry <= slice_co_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq (NWORDS=4 and NWORDS=1 instances).
// Subtract vectors are exercised when MULTIWORD_ADD_SUB_EN is defined.
module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v4 = 1'b0, ordy4 = 1'b0, s4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic        ir4, ov4, c4, busy4;
    logic [15:0] sum4;

    logic        v1 = 1'b0, ordy1 = 1'b0, s1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        ir1, ov1, c1, busy1;
    logic [3:0]  sum1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multiword_add_seq #(.NWORDS(4)) d4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
`ifdef MULTIWORD_ADD_SUB_EN
        .in_sub(s4),
`endif
        .out_valid(ov4), .out_ready(ordy4), .out_sum(sum4), .out_carry(c4), .busy(busy4)
    );

    multiword_add_seq #(.NWORDS(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_a(a1), .in_b(b1),
`ifdef MULTIWORD_ADD_SUB_EN
        .in_sub(s1),
`endif
        .out_valid(ov1), .out_ready(ordy1), .out_sum(sum1), .out_carry(c1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair to the NWORDS=4 instance and wait (bounded) for out_valid.
    // lat counts edges from the accept edge (inclusive) to the edge that raises out_valid.
    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic sub, output int lat);
        a4 = a; b4 = b; s4 = sub; v4 = 1'b1;
        tick();
        v4 = 1'b0; a4 = 16'hDEAD; b4 = 16'hBEEF;
        lat = 1;
        while (!ov4 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int acc_idx[$];
        logic spurious;

        // Reset state
        tick(); tick();
        chk("rst_ready",    32'(ir4),   32'h0);
        chk("rst_valid",    32'(ov4),   32'h0);
        chk("rst_sum",      32'(sum4),  32'h0);
        chk("rst_carry",    32'(c4),    32'h0);
        chk("rst_busy",     32'(busy4), 32'h0);
        rst = 1'b0;
        #1;
        chk("idle_ready",   32'(ir4),   32'h1);

        // 0x1234 + 0x1111, latency check
        op4(16'h1234, 16'h1111, 1'b0, lat);
        chk("add1_lat",     32'(lat),   32'd5);
        chk("add1_valid",   32'(ov4),   32'h1);
        chk("add1_sum",     32'(sum4),  32'h2345);
        chk("add1_carry",   32'(c4),    32'h0);
        chk("add1_busy",    32'(busy4), 32'h1);
        ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        chk("add1_drop",    32'(ov4),   32'h0);
        chk("add1_hold",    32'(sum4),  32'h2345);

        // Overflow ripple through all slices
        op4(16'hFFFF, 16'h0001, 1'b0, lat);
        chk("ovf_sum",      32'(sum4),  32'h0000);
        chk("ovf_carry",    32'(c4),    32'h1);
        ordy4 = 1'b1; tick(); ordy4 = 1'b0;

        op4(16'h8000, 16'h8000, 1'b0, lat);
        chk("msb_sum",      32'(sum4),  32'h0000);
        chk("msb_carry",    32'(c4),    32'h1);
        ordy4 = 1'b1; tick(); ordy4 = 1'b0;

        op4(16'h0FF0, 16'h0010, 1'b0, lat);
        chk("mid_sum",      32'(sum4),  32'h1000);
        chk("mid_carry",    32'(c4),    32'h0);
        ordy4 = 1'b1; tick(); ordy4 = 1'b0;

        // Backpressure: hold DONE for 10 cycles with a pending request
        op4(16'h0F0F, 16'h0101, 1'b0, lat);
        a4 = 16'h0005; b4 = 16'h0003; v4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid",  32'(ov4),  32'h1);
            chk("bp_sum",    32'(sum4), 32'h1010);
            chk("bp_ready",  32'(ir4),  32'h0);
        end
        ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        chk("bp_release_valid", 32'(ov4), 32'h0);
        chk("bp_release_ready", 32'(ir4), 32'h1);
        tick();
        v4 = 1'b0;
        chk("bp_pending_busy",  32'(busy4), 32'h1);
        lat = 1;
        while (!ov4 && lat < 20) begin tick(); lat++; end
        chk("bp_pending_lat",   32'(lat),  32'd5);
        chk("bp_pending_sum",   32'(sum4), 32'h0008);
        ordy4 = 1'b1; tick(); ordy4 = 1'b0;

        // Reset during RUN abandons the operation
        a4 = 16'hAAAA; b4 = 16'h5555; v4 = 1'b1;
        tick();
        v4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrun_busy",    32'(busy4), 32'h0);
        chk("rrun_valid",   32'(ov4),   32'h0);
        chk("rrun_sum",     32'(sum4),  32'h0);
        chk("rrun_carry",   32'(c4),    32'h0);
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov4 !== 1'b0) spurious = 1'b1;
        end
        chk("rrun_no_result", 32'(spurious), 32'h0);
        op4(16'h0005, 16'h0003, 1'b0, lat);
        chk("rrun_fresh_sum",   32'(sum4), 32'h0008);
        chk("rrun_fresh_carry", 32'(c4),   32'h0);
        ordy4 = 1'b1; tick(); ordy4 = 1'b0;

`ifdef MULTIWORD_ADD_SUB_EN
        // Subtract: borrow and no-borrow
        op4(16'h0005, 16'h0007, 1'b1, lat);
        chk("sub_neg_sum",   32'(sum4), 32'hFFFE);
        chk("sub_neg_carry", 32'(c4),   32'h0);
        ordy4 = 1'b1; tick(); ordy4 = 1'b0;
        op4(16'h0007, 16'h0005, 1'b1, lat);
        chk("sub_pos_sum",   32'(sum4), 32'h0002);
        chk("sub_pos_carry", 32'(c4),   32'h1);
        ordy4 = 1'b1; tick(); ordy4 = 1'b0;
        s4 = 1'b0;
`endif

        // NWORDS=1: single RUN cycle
        a1 = 4'hF; b1 = 4'h1; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        lat = 1;
        while (!ov1 && lat < 20) begin tick(); lat++; end
        chk("n1_lat",   32'(lat),  32'd2);
        chk("n1_sum",   32'(sum1), 32'h0);
        chk("n1_carry", 32'(c1),   32'h1);
        ordy1 = 1'b1;
        tick();

        // NWORDS=1 back-to-back with out_ready held high
        a1 = 4'h3; b1 = 4'h4; v1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ir1) acc_idx.push_back(k);
            if (ov1) chk("n1_b2b_sum", 32'(sum1), 32'h7);
        end
        v1 = 1'b0; ordy1 = 1'b0;
        chk("n1_b2b_count", 32'(acc_idx.size()), 32'd4);
        for (int i = 1; i < acc_idx.size(); i++)
            chk("n1_b2b_gap", 32'(acc_idx[i] - acc_idx[i-1]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
